// File: rtl/cat_trap_game_ctrl.sv
// cat_trap_game_ctrl: game sequencer for the 8x8 cat-trap board.
// Owns the 2-bit-per-cell board (0 empty, 1 wall, 2 cat) and the cursor.
// Walls are placed with the center button. After each wall the cat probes its
// neighbours in a fixed order and moves to the first one that is not a wall.
// The game reports WIN when the cat is trapped and LOSE when it reaches an edge.
// Optional build macro RANDOM_CAT_EN: an 8-bit LFSR picks the cat start cell
// at the beginning of each game.
module cat_trap_game_ctrl #(
   parameter int unsigned CAT_ROW0    = 3,
   parameter int unsigned CAT_COL0    = 3,
   parameter int unsigned HOLD_CYCLES = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_center,
   input  logic [2:0]  rd_row,
   input  logic [2:0]  rd_col,
   output logic [1:0]  rd_cell,
   output logic [2:0]  cursor_row,
   output logic [2:0]  cursor_col,
   output logic [2:0]  cat_row,
   output logic [2:0]  cat_col,
   output logic [6:0]  move_count,
   output logic        busy,
   output logic        result_valid,
   output logic        result_win,
   output logic [11:0] background
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [2:0]  CAT_R0 = CAT_ROW0[2:0];
   localparam logic [2:0]  CAT_C0 = CAT_COL0[2:0];
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_PLAY   = 3'd2,
      ST_SEARCH = 3'd3,
      ST_MOVE   = 3'd4,
      ST_WIN    = 3'd5,
      ST_LOSE   = 3'd6
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      board_q [64];
   logic [2:0]      cur_row_q, cur_col_q, cur_row_d, cur_col_d;
   logic [2:0]      cat_row_q, cat_col_q;
   logic [2:0]      tgt_row_q, tgt_col_q;
   logic [1:0]      probe_q;
   logic [6:0]      move_cnt_q;
   logic [HW-1:0]   hold_q, hold_d;
   logic            busy_q, busy_d;
   logic            rvalid_q, rvalid_d;
   logic            rwin_q, rwin_d;
   logic [11:0]     bg_q, bg_d;

   logic [2:0]      prb_row_s, prb_col_s;
   logic [1:0]      prb_cell_s, cur_cell_s;
   logic [2:0]      init_row_s, init_col_s;
   logic            tgt_edge_s;

`ifdef RANDOM_CAT_EN
   logic [7:0] lfsr_q;

   // Free-running Fibonacci LFSR (taps 8,6,5,4) used to randomise the cat start.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 8'h01;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   // Map the two low LFSR bits onto one of the four centre cells.
   always_comb begin
      init_row_s = 3'd3;
      init_col_s = 3'd3;
      case (lfsr_q[1:0])
         2'b00:   begin init_row_s = 3'd3; init_col_s = 3'd3; end
         2'b01:   begin init_row_s = 3'd3; init_col_s = 3'd4; end
         2'b10:   begin init_row_s = 3'd4; init_col_s = 3'd3; end
         2'b11:   begin init_row_s = 3'd4; init_col_s = 3'd4; end
         default: begin init_row_s = 3'd3; init_col_s = 3'd3; end
      endcase
   end
`else
   assign init_row_s = CAT_R0;
   assign init_col_s = CAT_C0;
`endif

   // Neighbour currently probed by SEARCH: down, up, right, left.
   always_comb begin
      prb_row_s = cat_row_q;
      prb_col_s = cat_col_q;
      case (probe_q)
         2'd0:    prb_row_s = cat_row_q + 3'd1;
         2'd1:    prb_row_s = cat_row_q - 3'd1;
         2'd2:    prb_col_s = cat_col_q + 3'd1;
         2'd3:    prb_col_s = cat_col_q - 3'd1;
         default: prb_row_s = cat_row_q;
      endcase
   end

   assign prb_cell_s = board_q[{prb_row_s, prb_col_s}];
   assign cur_cell_s = board_q[{cur_row_q, cur_col_q}];
   assign tgt_edge_s = (tgt_row_q == 3'd0) || (tgt_row_q == 3'd7) ||
                       (tgt_col_q == 3'd0) || (tgt_col_q == 3'd7);

   // Cursor movement; opposite directions in the same cycle cancel out.
   always_comb begin
      cur_row_d = cur_row_q;
      cur_col_d = cur_col_q;
      if (btn_up && !btn_down) begin
         cur_row_d = cur_row_q - 3'd1;
      end else if (btn_down && !btn_up) begin
         cur_row_d = cur_row_q + 3'd1;
      end else begin
         cur_row_d = cur_row_q;
      end
      if (btn_left && !btn_right) begin
         cur_col_d = cur_col_q - 3'd1;
      end else if (btn_right && !btn_left) begin
         cur_col_d = cur_col_q + 3'd1;
      end else begin
         cur_col_d = cur_col_q;
      end
   end

   // Next-state logic plus the status values that follow the next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_INIT; else state_d = ST_IDLE;
         ST_INIT:   state_d = ST_PLAY;
         ST_PLAY:   if (btn_center && (cur_cell_s == 2'd0)) state_d = ST_SEARCH;
                    else state_d = ST_PLAY;
         ST_SEARCH: if (prb_cell_s != 2'd1) state_d = ST_MOVE;
                    else if (probe_q == 2'd3) state_d = ST_WIN;
                    else state_d = ST_SEARCH;
         ST_MOVE:   if (tgt_edge_s) state_d = ST_LOSE; else state_d = ST_PLAY;
         ST_WIN,
         ST_LOSE:   if (start) state_d = ST_INIT;
                    else if (hold_q == HOLD_LAST) state_d = ST_IDLE;
                    else state_d = state_q;
         default:   state_d = ST_IDLE;
      endcase

      busy_d   = (state_d == ST_INIT) || (state_d == ST_SEARCH) || (state_d == ST_MOVE);
      rvalid_d = (state_d == ST_WIN) || (state_d == ST_LOSE);
      rwin_d   = (state_d == ST_WIN);
      if (state_d == ST_WIN) begin
         bg_d = 12'h0F0;
      end else if (state_d == ST_LOSE) begin
         bg_d = 12'hF00;
      end else begin
         bg_d = 12'hFFF;
      end
      if (rvalid_d && (state_q == state_d)) begin
         hold_d = hold_q + HW'(1);
      end else begin
         hold_d = '0;
      end
   end

   // State, board, cursor, cat and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         for (int i = 0; i < 64; i++) board_q[i] <= 2'd0;
         cur_row_q  <= 3'd0;
         cur_col_q  <= 3'd0;
         cat_row_q  <= CAT_R0;
         cat_col_q  <= CAT_C0;
         tgt_row_q  <= 3'd0;
         tgt_col_q  <= 3'd0;
         probe_q    <= 2'd0;
         move_cnt_q <= 7'd0;
         hold_q     <= '0;
         busy_q     <= 1'b0;
         rvalid_q   <= 1'b0;
         rwin_q     <= 1'b0;
         bg_q       <= 12'hFFF;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         busy_q   <= busy_d;
         rvalid_q <= rvalid_d;
         rwin_q   <= rwin_d;
         bg_q     <= bg_d;
         case (state_q)
            ST_INIT: begin
               for (int i = 0; i < 64; i++) board_q[i] <= 2'd0;
               board_q[{init_row_s, init_col_s}] <= 2'd2;
               cat_row_q  <= init_row_s;
               cat_col_q  <= init_col_s;
               cur_row_q  <= 3'd0;
               cur_col_q  <= 3'd0;
               move_cnt_q <= 7'd0;
            end
            ST_PLAY: begin
               if (btn_center) begin
                  if (cur_cell_s == 2'd0) begin
                     board_q[{cur_row_q, cur_col_q}] <= 2'd1;
                     probe_q <= 2'd0;
                     if (move_cnt_q != 7'd127) move_cnt_q <= move_cnt_q + 7'd1;
                  end
               end else begin
                  cur_row_q <= cur_row_d;
                  cur_col_q <= cur_col_d;
               end
            end
            ST_SEARCH: begin
               if (prb_cell_s != 2'd1) begin
                  tgt_row_q <= prb_row_s;
                  tgt_col_q <= prb_col_s;
               end else begin
                  probe_q <= probe_q + 2'd1;
               end
            end
            ST_MOVE: begin
               board_q[{cat_row_q, cat_col_q}] <= 2'd0;
               board_q[{tgt_row_q, tgt_col_q}] <= 2'd2;
               cat_row_q <= tgt_row_q;
               cat_col_q <= tgt_col_q;
            end
            default: ;
         endcase
      end
   end

   assign rd_cell      = board_q[{rd_row, rd_col}];
   assign cursor_row   = cur_row_q;
   assign cursor_col   = cur_col_q;
   assign cat_row      = cat_row_q;
   assign cat_col      = cat_col_q;
   assign move_count   = move_cnt_q;
   assign busy         = busy_q;
   assign result_valid = rvalid_q;
   assign result_win   = rwin_q;
   assign background   = bg_q;

endmodule

// File: tb/tb_cat_trap_game_ctrl.sv
// Directed testbench for cat_trap_game_ctrl with hand-computed expectations.
module tb_cat_trap_game_ctrl;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        btn_up, btn_down, btn_left, btn_right, btn_center;
   logic [2:0]  rd_row, rd_col;
   logic [1:0]  rd_cell;
   logic [2:0]  cursor_row, cursor_col, cat_row, cat_col;
   logic [6:0]  move_count;
   logic        busy, result_valid, result_win;
   logic [11:0] background;

   int n_checks = 0;
   int n_fail   = 0;
   int cur_r    = 0;
   int cur_c    = 0;
   int exp_mc   = 0;

   cat_trap_game_ctrl #(.CAT_ROW0(3), .CAT_COL0(3), .HOLD_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_center(btn_center),
      .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
      .cursor_row(cursor_row), .cursor_col(cursor_col),
      .cat_row(cat_row), .cat_col(cat_col), .move_count(move_count),
      .busy(busy), .result_valid(result_valid), .result_win(result_win),
      .background(background)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0 up, 1 down, 2 left, 3 right, 4 center, 5 start
   task automatic press(input int b);
      case (b)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         2: btn_left = 1'b1;
         3: btn_right = 1'b1;
         4: btn_center = 1'b1;
         default: start = 1'b1;
      endcase
      tick();
      {btn_up, btn_down, btn_left, btn_right, btn_center, start} = 6'b0;
   endtask

   task automatic read_cell(input logic [2:0] r, input logic [2:0] c, output logic [1:0] v);
      rd_row = r;
      rd_col = c;
      #1;
      v = rd_cell;
   endtask

   task automatic count_nonzero(output int n);
      logic [1:0] v;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         read_cell(i[5:3], i[2:0], v);
         if (v != 2'd0) n++;
      end
      tick();
   endtask

   task automatic go_to(input int r, input int c);
      int dr, dc;
      dr = (r - cur_r) & 7;
      dc = (c - cur_c) & 7;
      for (int i = 0; i < dr; i++) press(1);
      for (int i = 0; i < dc; i++) press(3);
      cur_r = r;
      cur_c = c;
      check("goto_row", cursor_row, r);
      check("goto_col", cursor_col, c);
   endtask

   // Place a wall; the cat is expected to move after probe index k.
   task automatic place(input int r, input int c, input int k, input int er, input int ec);
      go_to(r, c);
      press(4);
      exp_mc++;
      check("place_mc", move_count, exp_mc);
      repeat (k + 2) tick();
      check("place_cat_row", cat_row, er);
      check("place_cat_col", cat_col, ec);
      check("place_busy", busy, 0);
   endtask

   initial begin
      logic [1:0] v;
      int n;
      reset = 1'b1;
      {btn_up, btn_down, btn_left, btn_right, btn_center, start} = 6'b0;
      rd_row = 3'd0;
      rd_col = 3'd0;
      tick();
      tick();
      // Reset state
      check("rst_busy", busy, 0);
      check("rst_rvalid", result_valid, 0);
      check("rst_rwin", result_win, 0);
      check("rst_bg", background, 12'hFFF);
      check("rst_cur", {cursor_row, cursor_col}, 6'o00);
      check("rst_cat", {cat_row, cat_col}, 6'o33);
      check("rst_mc", move_count, 0);
      count_nonzero(n);
      check("rst_board", n, 0);
      reset = 1'b0;
      tick();

      // Test 1: new game
      press(5);
      check("init_busy", busy, 1);
      tick();
      check("play_busy", busy, 0);
      check("play_bg", background, 12'hFFF);
      read_cell(3'd3, 3'd3, v);
      check("init_cat_cell", v, 2);
      count_nonzero(n);
      check("init_board", n, 1);

      // Test 2: cursor wrap and cancelling pairs
      press(0);
      check("wrap_up", {cursor_row, cursor_col}, 6'o70);
      press(2);
      check("wrap_left", {cursor_row, cursor_col}, 6'o77);
      btn_up = 1'b1; btn_down = 1'b1;
      tick();
      btn_up = 1'b0; btn_down = 1'b0;
      check("updown_row", cursor_row, 7);
      btn_left = 1'b1; btn_right = 1'b1;
      tick();
      btn_left = 1'b0; btn_right = 1'b0;
      check("leftright_col", cursor_col, 7);
      cur_r = 7; cur_c = 7;

      // Test 3: wall below cat, cat goes up after probe k=1
      go_to(4, 3);
      press(4);
      exp_mc = 1;
      check("t3_mc", move_count, 1);
      check("t3_busy", busy, 1);
      read_cell(3'd4, 3'd3, v);
      check("t3_wall", v, 1);
      tick();
      tick();
      check("t3_cat_before_move", cat_row, 3);
      check("t3_busy_move", busy, 1);
      tick();
      check("t3_cat", {cat_row, cat_col}, 6'o23);
      check("t3_busy_done", busy, 0);
      read_cell(3'd3, 3'd3, v);
      check("t3_old_cell", v, 0);
      read_cell(3'd2, 3'd3, v);
      check("t3_new_cell", v, 2);

      // Test 6a: center on a wall, then on the cat, then start in PLAY
      press(4);
      check("wall_busy", busy, 0);
      check("wall_mc", move_count, 1);
      go_to(2, 3);
      press(4);
      check("catcell_busy", busy, 0);
      check("catcell_mc", move_count, 1);
      read_cell(3'd2, 3'd3, v);
      check("catcell_val", v, 2);
      press(5);
      check("play_start_busy", busy, 0);

      // Test 5: walk the cat to row 1 and out through the top edge
      place(3, 3, 1, 1, 3);
      place(5, 5, 0, 2, 3);
      place(6, 6, 1, 1, 3);
      go_to(2, 3);
      press(4);
      tick();
      tick();
      check("lose_pending", result_valid, 0);
      tick();
      check("lose_rvalid", result_valid, 1);
      check("lose_rwin", result_win, 0);
      check("lose_bg", background, 12'hF00);
      check("lose_cat", {cat_row, cat_col}, 6'o03);
      check("lose_mc", move_count, 5);
      check("lose_busy", busy, 0);
      repeat (3) tick();
      check("lose_hold", result_valid, 1);
      tick();
      check("idle_rvalid", result_valid, 0);
      check("idle_bg", background, 12'hFFF);
      read_cell(3'd0, 3'd3, v);
      check("idle_board_kept", v, 2);
      press(1);
      check("idle_btn_ignored", cursor_row, 2);

      // Test 4: new game and trap the cat at (3,3)
      press(5);
      check("g2_init_busy", busy, 1);
      tick();
      cur_r = 0; cur_c = 0; exp_mc = 0;
      check("g2_mc", move_count, 0);
      read_cell(3'd0, 3'd3, v);
      check("g2_cleared", v, 0);
      place(4, 3, 1, 2, 3);
      place(2, 2, 0, 3, 3);
      place(3, 4, 1, 2, 3);
      place(4, 2, 0, 3, 3);
      place(2, 3, 3, 3, 2);
      place(6, 6, 2, 3, 3);
      go_to(3, 2);
      press(4);
      repeat (3) tick();
      check("win_search_busy", busy, 1);
      check("win_pending", result_valid, 0);
      tick();
      check("win_rvalid", result_valid, 1);
      check("win_rwin", result_win, 1);
      check("win_bg", background, 12'h0F0);
      check("win_busy", busy, 0);
      check("win_mc", move_count, 7);
      tick();
      press(5);
      check("hold_start_busy", busy, 1);
      check("hold_start_rvalid", result_valid, 0);
      check("hold_start_bg", background, 12'hFFF);
      tick();
      read_cell(3'd3, 3'd2, v);
      check("g3_cleared", v, 0);
      check("g3_mc", move_count, 0);
      count_nonzero(n);
      check("g3_board", n, 1);

      // Test 6b: reset during SEARCH
      cur_r = 0; cur_c = 0;
      go_to(4, 3);
      press(4);
      check("srch_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_busy", busy, 0);
      check("rst2_mc", move_count, 0);
      check("rst2_cur", {cursor_row, cursor_col}, 6'o00);
      check("rst2_rvalid", result_valid, 0);
      check("rst2_bg", background, 12'hFFF);
      count_nonzero(n);
      check("rst2_board", n, 0);
      tick();
      check("rst2_idle_busy", busy, 0);
      check("rst2_cat", {cat_row, cat_col}, 6'o33);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cat_trap_game_ctrl.md
Name: cat_trap_game_ctrl

Overview:
- Game sequencer for the 8x8 cat-trap board.
- Owns the board-state array (2 bits per cell: 0 empty, 1 wall, 2 cat) and the cursor.
- Accepts debounced single-cycle button pulses, places walls, moves the cat by a fixed neighbour-probe schedule and detects win/lose.
- Feeds the VGA renderer through a combinational cell-read port plus status outputs.

Parameters:
- CAT_ROW0, 3, cat start row (0..7) when RANDOM_CAT_EN is absent.
- CAT_COL0, 3, cat start column (0..7) when RANDOM_CAT_EN is absent.
- HOLD_CYCLES, 50, cycles the WIN/LOSE result is held before returning to IDLE (>=1; counter width $clog2(HOLD_CYCLES+1)).

Ports:
- clk  in  1  system clock (slow game clock domain).
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a new game.
- btn_up, btn_down, btn_left, btn_right  in  1 each  cursor move pulses.
- btn_center  in  1  pulse: place wall at cursor.
- rd_row, rd_col  in  3 each  renderer read address.
- rd_cell  out  2  combinational board[rd_row][rd_col].
- cursor_row, cursor_col  out  3 each  current cursor.
- cat_row, cat_col  out  3 each  current cat position.
- move_count  out  7  walls placed this game, saturating at 127.
- busy  out  1  high in INIT/SEARCH/MOVE.
- result_valid  out  1  high in WIN/LOSE.
- result_win  out  1  1 in WIN, 0 otherwise.
- background  out  12  status colour: WHITE 12'hFFF; WIN 12'h0F0; LOSE 12'hF00.

Behaviour:
- Reset values:
  - Board all 0; cursor 0,0; cat = CAT_ROW0,CAT_COL0.
  - move_count 0, busy 0, result_valid 0, result_win 0, background 12'hFFF.
  - State IDLE, hold counter 0.
- States: IDLE, INIT, PLAY, SEARCH, MOVE, WIN, LOSE.
- IDLE: start -> INIT. All buttons ignored.
- INIT (1 cycle): clear all 64 cells, write 2 at the cat start cell, cursor 0,0, move_count 0 -> PLAY.
- PLAY, direction pulses:
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - Wraps modulo 8 (0-1 -> 7, 7+1 -> 0).
  - up+down in the same cycle: row unchanged. left+right in the same cycle: col unchanged.
- PLAY, btn_center:
  - Has priority; direction pulses in the same cycle are ignored.
  - If board[cursor] == 0: write 1 at that cell on this edge, move_count+1 (saturating), probe index 0 -> SEARCH.
  - If the cell is a wall or the cat: ignored, stay in PLAY.
- PLAY, start: ignored.
- SEARCH: one neighbour per cycle in fixed order:
  - k=0 row+1, k=1 row-1, k=2 col+1, k=3 col-1.
  - First neighbour != 1: latch the target -> MOVE (early exit).
  - k=3 is also a wall: -> WIN (cat trapped).
  - Latency: center to MOVE = k+1 cycles.
- MOVE (1 cycle): old cat cell <- 0, target cell <- 2, cat_row/col <- target.
  - New position on an edge (row or col 0 or 7): -> LOSE (cat escaped).
  - Otherwise -> PLAY.
- Neighbour indices are always in range: the cat is never on an edge while in PLAY/SEARCH.
- Cat start on an edge is a parameter error; behaviour is undefined.
- WIN/LOSE:
  - result_valid=1; result_win=1 in WIN; background green/red.
  - Board frozen and still readable.
  - Hold counter counts HOLD_CYCLES cycles, then -> IDLE. Outputs return to white/0; board retained until the next INIT.
  - start during the hold: -> INIT immediately.
- Reset mid-operation: synchronous return to reset values on the next edge; an in-progress SEARCH/MOVE is discarded.
- rd_cell reflects writes on the cycle after the write edge.

Optional Feature:
- RANDOM_CAT_EN defined:
  - Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'h01 on reset, advancing every cycle.
  - INIT picks the cat start from lfsr[1:0]: 00->(3,3), 01->(3,4), 10->(4,3), 11->(4,4).
  - CAT_ROW0/COL0 are used only as the reset value of cat_row/col.
- RANDOM_CAT_EN absent: no LFSR; INIT always uses CAT_ROW0, CAT_COL0.

Test Plan:
1. Reset, start, 1 idle cycle -> rd_cell(3,3)=2, all other cells 0, cursor 0,0, busy 0 in PLAY, background 12'hFFF.
2. Cursor at 0,0, btn_up then btn_left -> cursor 7,7; up+down together -> row unchanged.
3. Cursor to (4,3), center -> (4,3)=1, move_count=1.
   - SEARCH: k0 blocked, k1 free -> MOVE after 2 cycles.
   - Cat (2,3), old cell 0, back to PLAY.
4. Cat (3,3): pre-wall (4,3),(2,3),(3,4), then center at (3,2) -> WIN after 4 SEARCH cycles.
   - result_win=1, background 12'h0F0.
   - IDLE after HOLD_CYCLES.
5. Cat (1,3), center on (5,5) -> cat moves to (2,3).
   - Walk to row 1 first, then a move to (0,3) -> LOSE, background 12'hF00, result_win=0.
6. Center on the cat cell or an existing wall -> no write, move_count unchanged.
   - Reset asserted during SEARCH -> next cycle IDLE, board all 0, outputs at reset values.
